// File: rtl/sha_result_buffer.sv
// sha_result_buffer
//   Captures a multi-word hash result into a snapshot register. The snapshot
//   can be read in three ways:
//     - in parallel on out_words;
//     - one word at a time through a registered random-read port
//       (rd_addr is 1-based, data appears one cycle later);
//     - as a valid/ready stream of N_WORDS beats, word 0 first.
//
// Ports
//   clk, rst_n            single clock; asynchronous active-low reset
//   cap_en, in_words      capture request and result words
//                         (word k is at bits [k*DATA_W +: DATA_W])
//   clr                   synchronous clear of the flags and of any stream
//   rd_addr, out_var      random-read index and its registered data
//   out_words             parallel copy of the snapshot
//   str_start, str_ready  stream start request and sink ready
//   str_data, str_valid,
//   str_last              stream beat, driven from registers
//   res_valid             the snapshot holds a result that has not been streamed
//   busy                  a stream is in progress
//   overrun               sticky: a capture was refused while streaming
module sha_result_buffer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_WORDS = 8,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cap_en,
    input  logic [N_WORDS*DATA_W-1:0]  in_words,
    input  logic                       clr,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          out_var,
    output logic [N_WORDS*DATA_W-1:0]  out_words,
    input  logic                       str_start,
    input  logic                       str_ready,
    output logic [DATA_W-1:0]          str_data,
    output logic                       str_valid,
    output logic                       str_last,
    output logic                       res_valid,
    output logic                       busy,
    output logic                       overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

    state_e                      state_q,     state_d;
    logic [N_WORDS*DATA_W-1:0]   snap_q,      snap_d;
    logic [ADDR_W-1:0]           idx_q,       idx_d;
    logic [DATA_W-1:0]           out_var_q,   out_var_d;
    logic [DATA_W-1:0]           str_data_q,  str_data_d;
    logic                        str_valid_q, str_valid_d;
    logic                        str_last_q,  str_last_d;
    logic                        res_valid_q, res_valid_d;
    logic                        overrun_q,   overrun_d;

    logic                        busy_w;
    logic [ADDR_W-1:0]           nxt_idx;
    logic [DATA_W-1:0]           nxt_word;
    logic [DATA_W-1:0]           rd_word;
    logic                        rd_hit;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        out_var_d   = out_var_q;
        str_data_d  = str_data_q;
        str_valid_d = str_valid_q;
        str_last_d  = str_last_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;

        busy_w   = (state_q == STREAM);
        // Index of the word that the next presented beat will carry:
        // word 0 when a stream starts, otherwise the one after the current.
        nxt_idx  = busy_w ? (idx_q + 1'b1) : '0;
        nxt_word = '0;
        rd_word  = '0;
        rd_hit   = 1'b0;

        // Both selects read the pre-edge snapshot, so a capture on the same
        // edge never leaks into out_var or str_data.
        for (int unsigned k = 0; k < N_WORDS; k++) begin
            if (rd_addr == ADDR_W'(k + 1)) begin
                rd_hit  = 1'b1;
                rd_word = snap_q[k*DATA_W +: DATA_W];
            end
            if (nxt_idx == ADDR_W'(k)) begin
                nxt_word = snap_q[k*DATA_W +: DATA_W];
            end
        end

        if (rd_hit) begin
            out_var_d = rd_word;
        end

        if (clr) begin
            state_d     = IDLE;
            idx_d       = '0;
            str_valid_d = 1'b0;
            str_last_d  = 1'b0;
            res_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (cap_en) begin
                if (busy_w) begin
                    overrun_d = 1'b1;
                end else begin
                    snap_d      = in_words;
                    res_valid_d = 1'b1;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (str_start && res_valid_q && !cap_en) begin
                        state_d     = STREAM;
                        idx_d       = '0;
                        str_valid_d = 1'b1;
                        str_data_d  = nxt_word;
                        str_last_d  = (nxt_idx == LAST_IDX);
                    end
                end
                STREAM: begin
                    if (str_valid_q && str_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d     = IDLE;
                            idx_d       = '0;
                            str_valid_d = 1'b0;
                            str_last_d  = 1'b0;
                            res_valid_d = 1'b0;
                        end else begin
                            idx_d      = nxt_idx;
                            str_data_d = nxt_word;
                            str_last_d = (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            out_var_q   <= '0;
            str_data_q  <= '0;
            str_valid_q <= 1'b0;
            str_last_q  <= 1'b0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            out_var_q   <= out_var_d;
            str_data_q  <= str_data_d;
            str_valid_q <= str_valid_d;
            str_last_q  <= str_last_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_var   = out_var_q;
    assign out_words = snap_q;
    assign str_data  = str_data_q;
    assign str_valid = str_valid_q;
    assign str_last  = str_last_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == STREAM);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha_result_buffer.sv
module tb_sha_result_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clr;

    // Instance A: default geometry (8 x 32)
    logic         cap_a, start_a, ready_a;
    logic [3:0]   rd_a;
    logic [255:0] in_a;
    logic [31:0]  var_a, data_a;
    logic [255:0] words_a;
    logic         valid_a, last_a, resv_a, busy_a, ovr_a;

    // Instance B: 4 x 64
    logic         cap_b, start_b, ready_b;
    logic [2:0]   rd_b;
    logic [255:0] in_b;
    logic [63:0]  var_b, data_b;
    logic [255:0] words_b;
    logic         valid_b, last_b, resv_b, busy_b, ovr_b;

    sha_result_buffer #(.DATA_W(32), .N_WORDS(8), .ADDR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_a), .in_words(in_a), .clr(clr),
        .rd_addr(rd_a), .out_var(var_a), .out_words(words_a),
        .str_start(start_a), .str_ready(ready_a), .str_data(data_a),
        .str_valid(valid_a), .str_last(last_a), .res_valid(resv_a),
        .busy(busy_a), .overrun(ovr_a)
    );

    sha_result_buffer #(.DATA_W(64), .N_WORDS(4), .ADDR_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_b), .in_words(in_b), .clr(clr),
        .rd_addr(rd_b), .out_var(var_b), .out_words(words_b),
        .str_start(start_b), .str_ready(ready_b), .str_data(data_b),
        .str_valid(valid_b), .str_last(last_b), .res_valid(resv_b),
        .busy(busy_b), .overrun(ovr_b)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] w32(input int k);
        return 32'h1111_1111 * 32'(k + 1);
    endfunction

    function automatic logic [63:0] w64(input int k);
        return 64'h1111_1111_1111_1111 * 64'(k + 1);
    endfunction

    function automatic logic [255:0] pack32();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = w32(k);
        return r;
    endfunction

    function automatic logic [255:0] pack64();
        logic [255:0] r;
        for (int k = 0; k < 4; k++) r[k*64 +: 64] = w64(k);
        return r;
    endfunction

    logic [255:0] old_a, new_a;
    int           got;
    logic         stalled, prev_last;
    logic [31:0]  prev_data;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        old_a = pack32();
        new_a = {8{32'hAAAA_AAAA}};
        rst_n = 1'b0; clr = 1'b0;
        cap_a = 1'b0; start_a = 1'b0; ready_a = 1'b0; rd_a = '0; in_a = '0;
        cap_b = 1'b0; start_b = 1'b0; ready_b = 1'b0; rd_b = '0; in_b = '0;

        // Reset state
        #12;
        check("rst_words", words_a, 0);
        check("rst_var", var_a, 0);
        check("rst_data", data_a, 0);
        check("rst_flags", {valid_a, last_a, resv_a, busy_a, ovr_a}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Capture plus random read; the capture edge returns the old word
        in_a = old_a; cap_a = 1'b1; rd_a = 4'd3;
        tick; cap_a = 1'b0;
        check("cap_same_edge_read", var_a, 0);
        check("cap_words", words_a, old_a);
        check("cap_res_valid", resv_a, 1);
        tick;
        check("rd3", var_a, 32'h3333_3333);
        rd_a = 4'd8; tick;
        check("rd8", var_a, 32'h8888_8888);
        rd_a = 4'd0; tick;
        check("rd0_hold", var_a, 32'h8888_8888);
        rd_a = 4'd9; tick;
        check("rd9_hold", var_a, 32'h8888_8888);
        rd_a = 4'd1; tick;
        check("rd1", var_a, 32'h1111_1111);
        rd_a = 4'd0;

        // Stream with ready held high; capture on the last beat overruns
        ready_a = 1'b1; start_a = 1'b1; tick; start_a = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check("s2_valid", valid_a, 1);
            check("s2_data", data_a, w32(b));
            check("s2_last", last_a, (b == 7));
            if (b == 7) begin cap_a = 1'b1; in_a = new_a; end
            tick; cap_a = 1'b0;
        end
        in_a = old_a;
        check("s2_end_valid", valid_a, 0);
        check("s2_end_res_valid", resv_a, 0);
        check("s2_end_busy", busy_a, 0);
        check("s2_lastbeat_ovr", ovr_a, 1);
        check("s2_snap", words_a, old_a);
        clr = 1'b1; tick; clr = 1'b0;
        check("clr_ovr", ovr_a, 0);

        // Stream with ready pattern 1,0,0,1
        cap_a = 1'b1; tick; cap_a = 1'b0;
        ready_a = 1'b0; start_a = 1'b1; tick; start_a = 1'b0;
        got = 0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (!busy_a) break;
            ready_a = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (stalled) begin
                check("s3_stall_data", data_a, prev_data);
                check("s3_stall_last", last_a, prev_last);
            end
            if (valid_a && ready_a) begin
                check("s3_data", data_a, w32(got));
                check("s3_last", last_a, (got == 7));
                got++;
            end
            stalled = valid_a && !ready_a;
            prev_data = data_a; prev_last = last_a;
            tick;
        end
        check("s3_count", got, 8);
        check("s3_busy", busy_a, 0);

        // Capture during beat 4 is refused and flags overrun
        ready_a = 1'b1;
        cap_a = 1'b1; tick; cap_a = 1'b0;
        start_a = 1'b1; tick; start_a = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check("s4_data", data_a, w32(b));
            if (b == 3) begin cap_a = 1'b1; in_a = new_a; end
            tick; cap_a = 1'b0;
            if (b == 3) check("s4_ovr", ovr_a, 1);
        end
        in_a = old_a;
        check("s4_snap", words_a, old_a);

        // clr during beat 5, with a simultaneous capture that must be ignored
        cap_a = 1'b1; tick; cap_a = 1'b0;
        start_a = 1'b1; tick; start_a = 1'b0;
        for (int b = 0; b < 5; b++) begin
            check("s5_data", data_a, w32(b));
            if (b == 4) begin clr = 1'b1; cap_a = 1'b1; in_a = new_a; end
            tick;
        end
        clr = 1'b0; cap_a = 1'b0; in_a = old_a;
        check("s5_valid", valid_a, 0);
        check("s5_busy", busy_a, 0);
        check("s5_ovr", ovr_a, 0);
        check("s5_res_valid", resv_a, 0);
        check("s5_snap", words_a, old_a);
        start_a = 1'b1; tick; start_a = 1'b0;
        check("s5_start_ignored_busy", busy_a, 0);
        check("s5_start_ignored_valid", valid_a, 0);

        // Asynchronous reset mid-stream
        cap_a = 1'b1; tick; cap_a = 1'b0;
        start_a = 1'b1; tick; start_a = 1'b0;
        tick;
        check("s6_pre_busy", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_words", words_a, 0);
        check("s6_rst_var", var_a, 0);
        check("s6_rst_data", data_a, 0);
        check("s6_rst_flags", {valid_a, last_a, resv_a, busy_a, ovr_a}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick;
        check("s6_after_busy", busy_a, 0);
        check("s6_after_valid", valid_a, 0);

        // Instance B: 4 x 64
        in_b = pack64(); cap_b = 1'b1; rd_b = 3'd4;
        tick; cap_b = 1'b0;
        check("b_words", words_b, pack64());
        tick;
        check("b_rd4", var_b, w64(3));
        rd_b = 3'd5; tick;
        check("b_rd5_hold", var_b, w64(3));
        ready_b = 1'b1; start_b = 1'b1; tick; start_b = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("b_data", data_b, w64(b));
            check("b_last", last_b, (b == 3));
            tick;
        end
        check("b_end_busy", busy_b, 0);
        check("b_end_res_valid", resv_b, 0);
        cap_b = 1'b1; tick; cap_b = 1'b0;
        start_b = 1'b1; tick; start_b = 1'b0;
        tick;
        #3 rst_n = 1'b0;
        #1;
        check("b_rst_words", words_b, 0);
        check("b_rst_var", var_b, 0);
        check("b_rst_data", data_b, 0);
        check("b_rst_flags", {valid_b, last_b, resv_b, busy_b, ovr_b}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha_result_buffer.md
SHA_RESULT_BUFFER -- requirements
Module: sha_result_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning bits per result word.
REQ-002 The block SHALL have parameter N_WORDS, default 8, meaning words per result (legal: 2..15).
REQ-003 The block SHALL have parameter ADDR_W, default 4, meaning the read-address width (legal: 2^ADDR_W > N_WORDS).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state updating on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 The block SHALL have port cap_en, input, 1 bit: the capture request.
REQ-007 The block SHALL have port in_words, input, N_WORDS*DATA_W bits: the result words, with word k at bits [k*DATA_W +: DATA_W].
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of the flags and any stream.
REQ-009 The block SHALL have port rd_addr, input, ADDR_W bits: the 1-based random-read index.
REQ-010 The block SHALL have port out_var, output, DATA_W bits: the registered random-read data.
REQ-011 The block SHALL have port out_words, output, N_WORDS*DATA_W bits: the parallel snapshot.
REQ-012 The block SHALL have port str_start, input, 1 bit: the stream start request.
REQ-013 The block SHALL have port str_ready, input, 1 bit: the stream sink ready.
REQ-014 The block SHALL have ports str_data (DATA_W bits), str_valid (1 bit) and str_last (1 bit), all outputs: the stream beat.
REQ-015 The block SHALL have ports res_valid, busy and overrun, outputs of 1 bit each: snapshot holds an unconsumed result / stream in progress / sticky lost-capture flag.

Function
REQ-016 On a cap_en=1 edge with busy=0 and clr=0, the snapshot and out_words SHALL load in_words, and res_valid SHALL be set to 1.
REQ-017 On a cap_en=1 edge with busy=1, the snapshot SHALL be unchanged and overrun SHALL be set to 1.
REQ-018 On every edge with 1<=rd_addr<=N_WORDS, out_var SHALL load snapshot word rd_addr-1 as it was before that edge, giving 1-cycle latency; on an edge where a capture also occurs, out_var returns the old word.
REQ-019 When rd_addr=0 or rd_addr>N_WORDS, out_var SHALL hold its value.
REQ-020 The FSM SHALL have two states, IDLE and STREAM, with busy=1 exactly in STREAM.
REQ-021 In IDLE, a str_start=1 edge with res_valid=1, cap_en=0 and clr=0 SHALL enter STREAM with index 0; in the next cycle str_valid=1 and str_data=word 0.
REQ-022 In IDLE, str_start SHALL be ignored when res_valid=0 or when cap_en=1 in the same cycle; capture wins.
REQ-023 In STREAM, a beat SHALL transfer on each edge with str_valid=1 and str_ready=1, after which the index increments and str_data presents the next word in the following cycle.
REQ-024 While str_valid=1 and str_ready=0, str_data and str_last SHALL be held stable.
REQ-025 str_last SHALL equal 1 exactly while str_valid=1 and the index equals N_WORDS-1.
REQ-026 On the last-beat transfer, the block SHALL return to IDLE, clear str_valid to 0 and clear res_valid to 0; a cap_en in that same cycle sees busy=1 and therefore sets overrun.
REQ-027 str_start SHALL be ignored while in STREAM.
REQ-028 clr=1 SHALL have priority over all other inputs: on the next edge overrun=0, res_valid=0, str_valid=0 and the state is IDLE, any stream is aborted, any simultaneous cap_en is ignored, and the snapshot and out_words are retained.
REQ-029 str_data SHALL be driven from registers, with no combinational path from str_ready to str_data or str_valid.

Reset
REQ-030 While rst_n=0, the block SHALL be in state IDLE with index 0, and the snapshot, out_words, out_var, str_data, str_valid, str_last, res_valid, busy and overrun SHALL all be 0, asynchronously.
REQ-031 After rst_n deasserts, the first state change SHALL occur at the first rising clk edge at which rst_n=1.
REQ-032 A reset asserted mid-stream SHALL abort the stream immediately, with no partial beat held.

Verification
REQ-033 The bench SHALL cover: capture words 0x11111111..0x88888888 with cap_en for 1 cycle, then rd_addr=3 -> out_var=0x33333333 one cycle later; rd_addr=0 -> out_var holds.
REQ-034 The bench SHALL cover: str_start with str_ready=1 held -> 8 consecutive beats 0x11111111..0x88888888, str_last only on beat 8, then res_valid=0 and busy=0.
REQ-035 The bench SHALL cover: str_ready toggled 1,0,0,1,... during a stream -> str_data stable during stalls, each word delivered exactly once, order preserved.
REQ-036 The bench SHALL cover: cap_en with new data 0xAAAAAAAA.. during beat 4 -> overrun=1, remaining beats still old data, snapshot unchanged.
REQ-037 The bench SHALL cover: clr asserted during beat 5 -> str_valid=0 next cycle, IDLE, overrun=0; a following str_start is ignored because res_valid=0.
REQ-038 The bench SHALL cover: rst_n pulsed low mid-stream, asynchronous to clk -> all outputs 0 before the next clk edge; run again with N_WORDS=4 and DATA_W=64.
